// File: rtl/rt_pkg.sv
// Shared state encoding, LFSR constants and helpers for the multi-player reaction timer.
package rt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GO   = 2'd2,
    ST_DONE = 2'd3
  } rt_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, right-shifting.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/rt_ms_tick.sv
// Millisecond prescaler: one-cycle tick every DIV clocks, zeroed by a synchronous restart.
module rt_ms_tick #(
  parameter int unsigned DIV = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multi_player_reaction_core.sv
// Reaction-timing core: random arming delay, per-player millisecond capture, false starts,
// round winner and per-player best time.
module multi_player_reaction_core
  import rt_pkg::*;
#(
  parameter int unsigned N_PLAYERS       = 2,
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned TIME_W          = 14,
  parameter int unsigned DELAY_BASE_MS   = 1000,
  parameter int unsigned DELAY_RAND_BITS = 11,
  parameter int unsigned TIMEOUT_MS      = 9999
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        clear_best,
  input  logic [N_PLAYERS-1:0]        btn,
  output logic                        go_led,
  output logic                        busy,
  output logic                        round_done,
  output logic [N_PLAYERS*TIME_W-1:0] time_ms,
  output logic [N_PLAYERS-1:0]        hit,
  output logic [N_PLAYERS-1:0]        false_start,
  output logic [2:0]                  winner,
  output logic                        winner_valid,
  output logic [N_PLAYERS*TIME_W-1:0] best_ms
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1000;
  localparam int unsigned DLY_MAX  = DELAY_BASE_MS + (1 << DELAY_RAND_BITS) - 1;
  localparam int unsigned DLY_W    = $clog2(DLY_MAX + 2);
  localparam logic [TIME_W-1:0] TMO    = TIME_W'(TIMEOUT_MS);
  localparam logic [TIME_W-1:0] T_ONES = '1;

  typedef logic [TIME_W-1:0] ms_t;

  rt_state_e            state_q, state_d;
  logic [15:0]          lfsr_q;
  logic [N_PLAYERS-1:0] btn_q, press;
  logic [DLY_W-1:0]     dly_q, dly_d;
  ms_t                  elapsed_q, elapsed_d;
  logic [N_PLAYERS-1:0] hit_q, hit_d, fs_q, fs_d;
  ms_t                  time_q [N_PLAYERS];
  ms_t                  time_d [N_PLAYERS];
  ms_t                  best_q [N_PLAYERS];
  ms_t                  best_d [N_PLAYERS];
  logic [2:0]           winner_q, winner_d;
  logic                 wvalid_q, wvalid_d;
  logic                 go_q, busy_q, done_q;
  logic                 restart, tick, enter_done;
  ms_t                  win_t;

  rt_ms_tick #(.DIV(TICK_DIV)) u_tick (
    .clk      (clk),
    .rst_n    (reset),
    .restart_i(restart),
    .tick_o   (tick)
  );

  assign press      = btn & ~btn_q;
  assign enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    elapsed_d = elapsed_q;
    hit_d     = hit_q;
    fs_d      = fs_q;
    time_d    = time_q;
    best_d    = best_q;
    winner_d  = winner_q;
    wvalid_d  = wvalid_q;
    restart   = 1'b0;
    win_t     = T_ONES;
    case (state_q)
      ST_ARM: begin
        fs_d = fs_q | press;
        if (tick) dly_d = dly_q - 1'b1;
        // A press in the very last ARM cycle still counts as a false start.
        if (&fs_d) begin
          state_d = ST_DONE;
        end else if (tick && dly_q <= DLY_W'(1)) begin
          state_d   = ST_GO;
          restart   = 1'b1;
          elapsed_d = '0;
        end
      end
      ST_GO: begin
        for (int p = 0; p < N_PLAYERS; p++) begin
          if (press[p] && !fs_q[p] && !hit_q[p]) begin
            hit_d[p]  = 1'b1;
            time_d[p] = elapsed_q;
          end
        end
        if (tick && elapsed_q < TMO) elapsed_d = elapsed_q + 1'b1;
        if ((&(hit_d | fs_q)) || (elapsed_d >= TMO)) state_d = ST_DONE;
      end
      default: begin
        if (start) begin
          state_d  = ST_ARM;
          restart  = 1'b1;
          dly_d    = DLY_W'(DELAY_BASE_MS) + DLY_W'(lfsr_q[DELAY_RAND_BITS-1:0]);
          hit_d    = '0;
          fs_d     = '0;
          winner_d = '0;
          wvalid_d = 1'b0;
          for (int p = 0; p < N_PLAYERS; p++) time_d[p] = '0;
        end
      end
    endcase

    // Winner and best times are resolved from this cycle's captures, so they land with round_done.
    if (enter_done) begin
      wvalid_d = |hit_d;
      winner_d = '0;
      for (int p = 0; p < N_PLAYERS; p++) begin
        if (hit_d[p] && time_d[p] < win_t) begin
          win_t    = time_d[p];
          winner_d = 3'(p);
        end
      end
      for (int p = 0; p < N_PLAYERS; p++) begin
        if (hit_d[p] && time_d[p] < best_q[p]) best_d[p] = time_d[p];
      end
    end
    if (clear_best) begin
      for (int p = 0; p < N_PLAYERS; p++) best_d[p] = T_ONES;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= LFSR_SEED;
      btn_q     <= '0;
      dly_q     <= '0;
      elapsed_q <= '0;
      hit_q     <= '0;
      fs_q      <= '0;
      winner_q  <= '0;
      wvalid_q  <= 1'b0;
      go_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int p = 0; p < N_PLAYERS; p++) begin
        time_q[p] <= '0;
        best_q[p] <= T_ONES;
      end
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_step(lfsr_q);
      btn_q     <= btn;
      dly_q     <= dly_d;
      elapsed_q <= elapsed_d;
      hit_q     <= hit_d;
      fs_q      <= fs_d;
      winner_q  <= winner_d;
      wvalid_q  <= wvalid_d;
      go_q      <= (state_d == ST_GO);
      busy_q    <= (state_d == ST_ARM) || (state_d == ST_GO);
      done_q    <= enter_done;
      time_q    <= time_d;
      best_q    <= best_d;
    end
  end

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_pack
    assign time_ms[p*TIME_W +: TIME_W] = time_q[p];
    assign best_ms[p*TIME_W +: TIME_W] = best_q[p];
  end

  assign go_led       = go_q;
  assign busy         = busy_q;
  assign round_done   = done_q;
  assign hit          = hit_q;
  assign false_start  = fs_q;
  assign winner       = winner_q;
  assign winner_valid = wvalid_q;

endmodule
